// File: rtl/mem_ctrl_pkg.sv
// Shared op/state encodings and defaults for the memory access controller.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_LOAD  = 2'b00,
        OP_STORE = 2'b01,
        OP_PUSH  = 2'b10,
        OP_POP   = 2'b11
    } mem_op_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WRITE   = 3'd1,
        ST_READ    = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_RESP    = 3'd4
    } ctrl_state_e;

    localparam int MEM_DEPTH_DEFAULT = 256;

    function automatic logic op_is_write(mem_op_e op);
        return (op == OP_STORE) || (op == OP_PUSH);
    endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Request/response handshake between the control unit and the memory access controller.
interface mem_access_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_op;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_err;
    logic [DATA_W-1:0] rsp_rdata;

    modport master (
        output req_valid, req_op, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_err, rsp_rdata
    );

    modport slave (
        input  req_valid, req_op, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_err, rsp_rdata
    );
endinterface

// File: rtl/mem_stack_ptr.sv
// Full-descending stack pointer: SP register, push/pop target addresses and
// overflow/underflow flags. sp == MEM_DEPTH means the stack is empty.
module mem_stack_ptr
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int MEM_DEPTH = MEM_DEPTH_DEFAULT
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              push_done,
    input  logic              pop_done,
    output logic [ADDR_W-1:0] sp,
    output logic [ADDR_W-1:0] push_addr,
    output logic [ADDR_W-1:0] pop_addr,
    output logic              overflow,
    output logic              underflow
);
    localparam logic [ADDR_W-1:0] SP_EMPTY = ADDR_W'(MEM_DEPTH);

    logic [ADDR_W-1:0] sp_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sp_q <= SP_EMPTY;
        end else if (push_done) begin
            sp_q <= sp_q - ADDR_W'(1);
        end else if (pop_done) begin
            sp_q <= sp_q + ADDR_W'(1);
        end
    end

    assign sp        = sp_q;
    assign push_addr = sp_q - ADDR_W'(1);
    assign pop_addr  = sp_q;
    assign overflow  = (sp_q == '0);
    assign underflow = (sp_q == SP_EMPTY);

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory access controller: one load/store/push/pop at a time, single-cycle memory strobes,
// registered read data. PUSH/POP and the stack pointer exist only with MEM_STACK_OPS_EN defined.
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MEM_DEPTH = MEM_DEPTH_DEFAULT
) (
    input  logic              clk,
    input  logic              reset_n,
    mem_access_ctrl_if.slave  req_if,
    output logic [ADDR_W-1:0] sp,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_in,
    output logic              mem_write_signal,
    output logic              mem_read_signal,
    input  logic [DATA_W-1:0] mem_data_out
);
    localparam logic [2:0] S_IDLE    = 3'(ST_IDLE);
    localparam logic [2:0] S_WRITE   = 3'(ST_WRITE);
    localparam logic [2:0] S_READ    = 3'(ST_READ);
    localparam logic [2:0] S_CAPTURE = 3'(ST_CAPTURE);
    localparam logic [2:0] S_RESP    = 3'(ST_RESP);

    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(MEM_DEPTH);

    logic [2:0]        state;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;

    mem_op_e           req_op_e;
    logic              accept;
    logic              addr_oob;
    logic              req_err;
    logic [ADDR_W-1:0] eff_addr;

    assign req_op_e = mem_op_e'(req_if.req_op);
    assign accept   = req_if.req_valid && (state == S_IDLE);
    assign addr_oob = ({1'b0, req_if.req_addr} >= DEPTH_X);

`ifdef MEM_STACK_OPS_EN
    mem_op_e           op_q;
    logic              push_done;
    logic              pop_done;
    logic [ADDR_W-1:0] push_addr;
    logic [ADDR_W-1:0] pop_addr;
    logic              stk_overflow;
    logic              stk_underflow;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_q <= OP_LOAD;
        end else if (accept) begin
            op_q <= req_op_e;
        end
    end

    // SP moves on the edge leaving WRITE/CAPTURE, i.e. entering RESP; errors never get there.
    assign push_done = (state == S_WRITE)   && (op_q == OP_PUSH);
    assign pop_done  = (state == S_CAPTURE) && (op_q == OP_POP);

    mem_stack_ptr #(
        .ADDR_W    (ADDR_W),
        .MEM_DEPTH (MEM_DEPTH)
    ) u_stack_ptr (
        .clk       (clk),
        .reset_n   (reset_n),
        .push_done (push_done),
        .pop_done  (pop_done),
        .sp        (sp),
        .push_addr (push_addr),
        .pop_addr  (pop_addr),
        .overflow  (stk_overflow),
        .underflow (stk_underflow)
    );
`else
    assign sp = '0;
`endif

    always_comb begin
        eff_addr = req_if.req_addr;
        req_err  = 1'b0;
        case (req_op_e)
            OP_LOAD, OP_STORE: req_err = addr_oob;
`ifdef MEM_STACK_OPS_EN
            OP_PUSH: begin
                eff_addr = push_addr;
                req_err  = stk_overflow;
            end
            OP_POP: begin
                eff_addr = pop_addr;
                req_err  = stk_underflow;
            end
`endif
            default: req_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_if.req_valid) begin
                        addr_q  <= eff_addr;
                        wdata_q <= req_if.req_wdata;
                        err_q   <= req_err;
                        if (req_err) begin
                            state <= S_RESP;
                        end else if (op_is_write(req_op_e)) begin
                            state <= S_WRITE;
                        end else begin
                            state <= S_READ;
                        end
                    end
                end
                S_WRITE:   state <= S_RESP;
                S_READ:    state <= S_CAPTURE;
                S_CAPTURE: begin
                    rdata_q <= mem_data_out;
                    state   <= S_RESP;
                end
                S_RESP:    state <= S_IDLE;
                default:   state <= S_IDLE;
            endcase
        end
    end

    // Strobes decode straight from the state register so an async reset drops them at once.
    assign mem_write_signal = (state == S_WRITE);
    assign mem_read_signal  = (state == S_READ);
    assign mem_addr         = addr_q;
    assign mem_data_in      = wdata_q;

    assign req_if.req_ready = (state == S_IDLE);
    assign req_if.rsp_valid = (state == S_RESP);
    assign req_if.rsp_err   = (state == S_RESP) && err_q;
    assign req_if.rsp_rdata = rdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: behavioural memory, transaction-level reference model,
// directed plus randomized requests. Follows MEM_STACK_OPS_EN like the design does.
module tb_mem_access_ctrl;
    localparam int DEPTH = 256;
`ifdef MEM_STACK_OPS_EN
    localparam bit STACK_EN = 1'b1;
`else
    localparam bit STACK_EN = 1'b0;
`endif

    logic        clk;
    logic        reset_n;
    logic [31:0] sp;
    logic [31:0] mem_addr;
    logic [31:0] mem_data_in;
    logic        mem_write_signal;
    logic        mem_read_signal;
    logic [31:0] mem_data_out;
    logic        mem_clear;

    mem_access_ctrl_if #(.ADDR_W(32), .DATA_W(32)) ifc ();

    mem_access_ctrl #(.ADDR_W(32), .DATA_W(32), .MEM_DEPTH(DEPTH)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .req_if           (ifc),
        .sp               (sp),
        .mem_addr         (mem_addr),
        .mem_data_in      (mem_data_in),
        .mem_write_signal (mem_write_signal),
        .mem_read_signal  (mem_read_signal),
        .mem_data_out     (mem_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory block: synchronous write, registered read data one cycle after the strobe.
    logic [31:0] mem_model [DEPTH];
    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < DEPTH; i++) mem_model[i] <= '0;
        end else begin
            if (mem_write_signal && mem_addr < DEPTH) mem_model[mem_addr[7:0]] <= mem_data_in;
            if (mem_read_signal && mem_addr < DEPTH) mem_data_out <= mem_model[mem_addr[7:0]];
        end
    end

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] ref_mem [DEPTH];
    logic [31:0] ref_sp;
    logic [31:0] ref_rdata;

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic reset_model();
        ref_sp    = STACK_EN ? 32'(DEPTH) : 32'd0;
        ref_rdata = '0;
    endtask

    // One request, end to end: model outcome, drive, observe strobes and response timing.
    task automatic run_req(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] wdata);
        logic        exp_err;
        logic        is_wr;
        logic [31:0] eaddr;
        int          exp_lat;
        int          n_wr;
        int          n_rd;
        int          lat;
        is_wr = (op == 2'b01) || (op == 2'b10);
        case (op)
            2'b00, 2'b01: begin eaddr = addr;       exp_err = (addr >= DEPTH); end
            2'b10:        begin eaddr = ref_sp - 1; exp_err = !STACK_EN || (ref_sp == 0); end
            default:      begin eaddr = ref_sp;     exp_err = !STACK_EN || (ref_sp == DEPTH); end
        endcase
        exp_lat = exp_err ? 1 : (is_wr ? 2 : 3);
        if (!exp_err) begin
            if (is_wr) ref_mem[eaddr[7:0]] = wdata;
            else       ref_rdata = ref_mem[eaddr[7:0]];
            if (op == 2'b10)      ref_sp = ref_sp - 1;
            else if (op == 2'b11) ref_sp = ref_sp + 1;
        end

        @(negedge clk);
        check1("req_ready_idle", ifc.req_ready, 1'b1);
        ifc.req_valid = 1'b1;
        ifc.req_op    = op;
        ifc.req_addr  = addr;
        ifc.req_wdata = wdata;
        @(posedge clk);
        #1 ifc.req_valid = 1'b0;

        n_wr = 0; n_rd = 0; lat = 0;
        for (int k = 1; k <= 6 && lat == 0; k++) begin
            @(negedge clk);
            if (mem_write_signal) begin
                n_wr++;
                check32("wr_cycle", k, 1);
                check32("wr_addr", mem_addr, eaddr);
                check32("wr_data", mem_data_in, wdata);
            end
            if (mem_read_signal) begin
                n_rd++;
                check32("rd_cycle", k, 1);
                check32("rd_addr", mem_addr, eaddr);
            end
            if (ifc.rsp_valid) lat = k;
        end
        check32("rsp_latency", lat, exp_lat);
        check32("n_write_strobes", n_wr, (!exp_err && is_wr) ? 1 : 0);
        check32("n_read_strobes", n_rd, (!exp_err && !is_wr) ? 1 : 0);
        if (lat != 0) begin
            check1("rsp_err", ifc.rsp_err, exp_err);
            check32("rsp_rdata", ifc.rsp_rdata, ref_rdata);
            check32("sp_after", sp, ref_sp);
        end
        @(negedge clk);
        check1("rsp_valid_pulse", ifc.rsp_valid, 1'b0);
        check32("rsp_rdata_hold", ifc.rsp_rdata, ref_rdata);
    endtask

    logic [31:0] q_addr [3];
    logic [31:0] q_data [3];
    int          wr_cyc [3];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int          idx;
        int          nw;
        logic        rdy;
        logic [1:0]  op;
        logic [31:0] a;
        int          r;

        ifc.req_valid = 1'b0;
        ifc.req_op    = 2'b00;
        ifc.req_addr  = '0;
        ifc.req_wdata = '0;
        reset_n       = 1'b0;
        mem_clear     = 1'b1;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        reset_model();

        repeat (3) @(posedge clk);
        @(negedge clk);
        check1("rst_req_ready", ifc.req_ready, 1'b1);
        check1("rst_rsp_valid", ifc.rsp_valid, 1'b0);
        check1("rst_rsp_err", ifc.rsp_err, 1'b0);
        check32("rst_rsp_rdata", ifc.rsp_rdata, 0);
        check32("rst_mem_addr", mem_addr, 0);
        check32("rst_mem_data_in", mem_data_in, 0);
        check1("rst_mem_write", mem_write_signal, 1'b0);
        check1("rst_mem_read", mem_read_signal, 1'b0);
        check32("rst_sp", sp, ref_sp);
        reset_n   = 1'b1;
        mem_clear = 1'b0;

        // Directed basics and address boundaries
        run_req(2'b01, 32'd10, 32'd123);
        run_req(2'b00, 32'd10, 32'd0);
        run_req(2'b00, 32'd256, 32'd0);
        run_req(2'b01, 32'd255, 32'h5A5A_0001);
        run_req(2'b00, 32'd255, 32'd0);
        run_req(2'b01, 32'hFFFF_FFFF, 32'h1);
        run_req(2'b00, 32'd0, 32'd0);

        // Stack sequence
        run_req(2'b10, 32'd0, 32'hAA);
        run_req(2'b10, 32'd0, 32'hBB);
        run_req(2'b11, 32'd0, 32'd0);
        run_req(2'b11, 32'd0, 32'd0);
        run_req(2'b11, 32'd0, 32'd0);

        // Back-to-back stores with req_valid held high
        for (int j = 0; j < 3; j++) begin
            q_addr[j] = 32'd20 + 32'(j);
            q_data[j] = $urandom;
            wr_cyc[j] = -1;
        end
        @(negedge clk);
        idx = 0; nw = 0;
        ifc.req_valid = 1'b1;
        ifc.req_op    = 2'b01;
        ifc.req_addr  = q_addr[0];
        ifc.req_wdata = q_data[0];
        for (int cyc = 0; cyc < 12; cyc++) begin
            check1("queued_ready", ifc.req_ready, (cyc < 9) ? (cyc % 3 == 0) : 1'b1);
            if (mem_write_signal) begin
                if (nw < 3) begin
                    check32("queued_wr_addr", mem_addr, q_addr[nw]);
                    check32("queued_wr_data", mem_data_in, q_data[nw]);
                    wr_cyc[nw] = cyc;
                end
                nw++;
            end
            rdy = ifc.req_ready;
            @(posedge clk);
            #1;
            if (rdy && ifc.req_valid) begin
                idx++;
                if (idx == 3) begin
                    ifc.req_valid = 1'b0;
                end else begin
                    ifc.req_addr  = q_addr[idx];
                    ifc.req_wdata = q_data[idx];
                end
            end
            @(negedge clk);
        end
        check32("queued_n_writes", nw, 3);
        for (int j = 0; j < 3; j++) begin
            check32("queued_wr_spacing", wr_cyc[j], 3 * j + 1);
            ref_mem[q_addr[j][7:0]] = q_data[j];
        end
        run_req(2'b00, 32'd21, 32'd0);

        // Randomized mix
        for (int i = 0; i < 40; i++) begin
            r  = $urandom_range(0, 9);
            op = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 8) ? 2'b10 : 2'b11;
            if ($urandom_range(0, 9) == 0) a = 32'd256 + 32'($urandom_range(0, 1000));
            else if ($urandom_range(0, 1) == 0) a = 32'($urandom_range(0, 15));
            else a = 32'($urandom_range(0, 255));
            run_req(op, a, $urandom);
        end

        // Fill to overflow, then drain to underflow
        while (STACK_EN && ref_sp != 0) run_req(2'b10, 32'd0, $urandom);
        run_req(2'b10, 32'd0, 32'hDEAD);
        while (STACK_EN && ref_sp != DEPTH) run_req(2'b11, 32'd0, 32'd0);
        run_req(2'b11, 32'd0, 32'd0);

        // Reset in the middle of a read
        run_req(2'b10, 32'd0, 32'h77);
        @(negedge clk);
        ifc.req_valid = 1'b1;
        ifc.req_op    = 2'b00;
        ifc.req_addr  = 32'd10;
        @(posedge clk);
        #1 ifc.req_valid = 1'b0;
        @(negedge clk);
        check1("rd_strobe_before_rst", mem_read_signal, 1'b1);
        #1 reset_n = 1'b0;
        #1;
        check1("rd_strobe_async_drop", mem_read_signal, 1'b0);
        check1("rst_no_rsp_now", ifc.rsp_valid, 1'b0);
        reset_model();
        repeat (2) begin
            @(negedge clk);
            check1("rst_no_rsp_held", ifc.rsp_valid, 1'b0);
        end
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check1("post_rst_no_rsp", ifc.rsp_valid, 1'b0);
        end
        check1("post_rst_ready", ifc.req_ready, 1'b1);
        check32("post_rst_sp", sp, ref_sp);
        check32("post_rst_rdata", ifc.rsp_rdata, 0);
        run_req(2'b00, 32'd10, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
